// File: rtl/ccff_loader_if.sv
// ccff_loader_if: byte-stream handshake between the bitstream host and the
// configuration-chain loader.
//   cfg_data  : bitstream byte, shifted into the chain LSB first
//   cfg_valid : host presents a byte
//   cfg_ready : loader accepts the byte in this cycle (valid && ready)
// master = host side, slave = loader side.
interface ccff_loader_if;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;

    modport master (output cfg_data, output cfg_valid, input cfg_ready);
    modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_loader.sv
// ccff_loader: serialises a host byte stream into the CLB configuration chain
// (LOAD), or rotates the chain once through itself while comparing every bit
// leaving ccff_tail against an expected byte stream (VERIFY).
//
// Ports:
//   prog_clk      : programming clock, the only clock
//   pReset        : asynchronous active-high reset
//   cmd_start     : one-cycle start pulse, honoured only in IDLE
//   cmd_verify    : sampled with cmd_start, 0 = LOAD, 1 = VERIFY
//   cmd_abort     : terminate the running operation, no done pulse
//   cfg           : byte handshake (slave side)
//   ccff_head     : serial data into the chain
//   ccff_tail     : serial data out of the chain
//   ccff_shift_en : chain shifts on the next rising edge when 1
//   busy          : operation in progress (LOAD, VERIFY or DONE)
//   done          : one-cycle pulse on normal completion
//   verify_fail   : sticky VERIFY mismatch flag, cleared by cmd_start
//   mismatch_cnt  : saturating VERIFY mismatch count, cleared by cmd_start
//
// state  | meaning
// IDLE   | waiting for cmd_start, chain held
// LOAD   | shifting host bytes into the chain
// VERIFY | rotating the chain and comparing against host bytes
// DONE   | one-cycle completion pulse
module ccff_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic             prog_clk,
    input  logic             pReset,
    input  logic             cmd_start,
    input  logic             cmd_verify,
    input  logic             cmd_abort,
    ccff_loader_if.slave     cfg,
    output logic             ccff_head,
    input  logic             ccff_tail,
    output logic             ccff_shift_en,
    output logic             busy,
    output logic             done,
    output logic             verify_fail,
    output logic [CNT_W-1:0] mismatch_cnt
);
    localparam int REM_W = $clog2(CHAIN_LEN + 1);
    // Common width so rem and sh_n compare correctly even for tiny chains.
    localparam int CMP_W = (REM_W > 4) ? REM_W : 4;

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    state_t           state, state_nxt;
    logic [7:0]       sh;
    logic [3:0]       sh_n;
    logic [REM_W-1:0] rem;
    logic             active;
    logic             accept;
    logic             last_shift;
    logic             mismatch;

    assign active        = (state == LOAD) || (state == VERIFY);
    assign ccff_shift_en = active && (sh_n != 4'd0) && (rem != '0);
    // A new byte may land in the same cycle the last held bit shifts out, so
    // consecutive bytes stream without a bubble. Bytes are refused once the
    // remaining chain length is already covered by the held bits.
    assign cfg.cfg_ready = active
                           && ((sh_n == 4'd0) || ((sh_n == 4'd1) && ccff_shift_en))
                           && (CMP_W'(rem) > CMP_W'(sh_n));
    assign accept        = cfg.cfg_valid && cfg.cfg_ready;
    assign last_shift    = ccff_shift_en && (rem == REM_W'(1));
    // Compare uses ccff_tail as seen at the edge that shifts the chain.
    assign mismatch      = (state == VERIFY) && ccff_shift_en && (ccff_tail != sh[0]);

    // In VERIFY the tail loops straight back to the head, so a full pass
    // leaves the chain contents unchanged.
    assign ccff_head = (state == LOAD)   ? sh[0] :
                       (state == VERIFY) ? ccff_tail : 1'b0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    state_nxt = cmd_verify ? VERIFY : LOAD;
                end
            end
            LOAD, VERIFY: begin
                if (cmd_abort) begin
                    state_nxt = IDLE;
                end else if (last_shift) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge prog_clk or posedge pReset) begin
        if (pReset) begin
            sh           <= '0;
            sh_n         <= '0;
            rem          <= '0;
            verify_fail  <= 1'b0;
            mismatch_cnt <= '0;
        end else if ((state == IDLE) && cmd_start) begin
            sh_n         <= '0;
            rem          <= REM_W'(CHAIN_LEN);
            verify_fail  <= 1'b0;
            mismatch_cnt <= '0;
        end else if (active) begin
            if (ccff_shift_en) begin
                sh   <= sh >> 1;
                sh_n <= sh_n - 4'd1;
                rem  <= rem - REM_W'(1);
            end
            // Abort wins over a same-cycle handshake; that byte is dropped.
            if (cmd_abort) begin
                sh_n <= '0;
            end else if (accept) begin
                sh   <= cfg.cfg_data;
                sh_n <= 4'd8;
            end
            if (mismatch) begin
                verify_fail <= 1'b1;
                if (mismatch_cnt != '1) begin
                    mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_ccff_loader.sv
module tb_ccff_loader;
    localparam int L       = 20;
    localparam int CW      = 4;
    localparam int NB      = (L + 7) / 8;
    localparam int CNT_MAX = (1 << CW) - 1;

    typedef struct {
        logic         vf;
        logic [CW-1:0] cnt;
        logic [L-1:0] chain;
        int           lat;
        int           hs;
        int           shifts;
    } exp_t;

    logic          prog_clk = 1'b0;
    logic          pReset;
    logic          cmd_start, cmd_verify, cmd_abort;
    logic          ccff_head, ccff_tail, ccff_shift_en;
    logic          busy, done, verify_fail;
    logic [CW-1:0] mismatch_cnt;

    ccff_loader_if cfg ();

    ccff_loader #(.CHAIN_LEN(L), .CNT_W(CW)) dut (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .cmd_start     (cmd_start),
        .cmd_verify    (cmd_verify),
        .cmd_abort     (cmd_abort),
        .cfg           (cfg),
        .ccff_head     (ccff_head),
        .ccff_tail     (ccff_tail),
        .ccff_shift_en (ccff_shift_en),
        .busy          (busy),
        .done          (done),
        .verify_fail   (verify_fail),
        .mismatch_cnt  (mismatch_cnt)
    );

    always #5 prog_clk = ~prog_clk;

    // Behavioural chain: head enters bit 0, tail leaves from bit L-1.
    logic [L-1:0] chain;
    assign ccff_tail = chain[L-1];
    always @(posedge prog_clk) begin
        if (ccff_shift_en) chain <= {chain[L-2:0], ccff_head};
    end

    int cyc = 0;
    always @(posedge prog_clk) cyc <= cyc + 1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   shift_cnt = 0, hs_cnt = 0, start_cyc = 0, done_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s got %0h want %0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Monitor: samples mid-cycle, pops the scoreboard on every done pulse.
    always @(negedge prog_clk) begin
        exp_t e;
        if (cmd_start && !busy && !pReset) begin
            shift_cnt = 0;
            hs_cnt    = 0;
            start_cyc = cyc;
        end
        if (ccff_shift_en) shift_cnt++;
        if (cfg.cfg_valid && cfg.cfg_ready && !cmd_abort) hs_cnt++;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("verify_fail", verify_fail, e.vf);
                chk("mismatch_cnt", mismatch_cnt, e.cnt);
                chk("chain", chain, e.chain);
                chk("latency", cyc - start_cyc + 1, e.lat);
                chk("handshakes", hs_cnt, e.hs);
                chk("shift_cycles", shift_cnt, e.shifts);
            end
        end
    end

    // Reference: LOAD writes the first L stream bits, VERIFY leaves the chain
    // alone and counts differing bits against what currently sits in it.
    function automatic exp_t model(input logic verify, input logic [8*NB-1:0] stream,
                                   input int gaps);
        exp_t e;
        int   m = 0;
        e.chain = chain;
        for (int i = 0; i < L; i++) begin
            if (verify) begin
                if (chain[L-1-i] != stream[i]) m++;
            end else begin
                e.chain[L-1-i] = stream[i];
            end
        end
        e.vf     = (m != 0);
        e.cnt    = CW'((m > CNT_MAX) ? CNT_MAX : m);
        e.lat    = L + 3 + gaps;
        e.hs     = NB;
        e.shifts = L;
        return e;
    endfunction

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // gap > 0: hold valid low for gap cycles after the loader becomes ready.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        if (gap > 0) begin
            cfg.cfg_valid = 1'b0;
            while (!cfg.cfg_ready && n < 200) begin tick(); n++; end
            repeat (gap) tick();
        end
        cfg.cfg_data  = b;
        cfg.cfg_valid = 1'b1;
        while (!cfg.cfg_ready && n < 400) begin tick(); n++; end
        if (n >= 400) chk("ready_timeout", 0, 1);
        tick();
    endtask

    task automatic run_op(input logic verify, input logic [8*NB-1:0] stream,
                          input int g1, input int g2, input bit glitch);
        int n = 0;
        sb.push_back(model(verify, stream, g1 + g2));
        cmd_verify = verify;
        cmd_start  = 1'b1;
        tick();
        cmd_start  = 1'b0;
        cmd_verify = 1'b0;
        send_byte(stream[7:0], 0);
        if (glitch) begin
            cmd_start  = 1'b1;
            cmd_verify = ~verify;
            tick();
            cmd_start  = 1'b0;
            cmd_verify = 1'b0;
        end
        send_byte(stream[15:8], g1);
        send_byte(stream[23:16], g2);
        cfg.cfg_valid = 1'b0;
        while (sb.size() != 0 && n < 300) begin tick(); n++; end
        if (n >= 300) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
        tick();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_shift_en"}, ccff_shift_en, 0);
        chk({tag, "_head"}, ccff_head, 0);
        chk({tag, "_ready"}, cfg.cfg_ready, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_verify_fail"}, verify_fail, 0);
        chk({tag, "_mismatch_cnt"}, mismatch_cnt, 0);
    endtask

    function automatic logic [8*NB-1:0] chain_stream();
        logic [8*NB-1:0] s;
        for (int i = 0; i < 8 * NB; i++)
            s[i] = (i < L) ? chain[L-1-i] : 1'($urandom_range(0, 1));
        return s;
    endfunction

    initial begin
        logic [8*NB-1:0] base, s;
        logic [7:0]      b;
        int              n, dc, sc;

        pReset        = 1'b1;
        cmd_start     = 1'b0;
        cmd_verify    = 1'b0;
        cmd_abort     = 1'b0;
        cfg.cfg_valid = 1'b0;
        cfg.cfg_data  = 8'h00;
        chain         = L'($urandom);
        repeat (3) @(posedge prog_clk);
        #1;
        check_reset("reset");
        #2 pReset = 1'b0;
        tick();

        base = {8'h0F, 8'h3C, 8'hA5};
        run_op(1'b0, base, 0, 0, 1'b0);                  // basic LOAD, done in cycle 23
        run_op(1'b0, base, 5, 5, 1'b0);                  // throttled, 10 cycles later
        run_op(1'b1, base, 0, 0, 1'b0);                  // matching VERIFY
        run_op(1'b1, {8'h0F, 8'h3D, 8'hA5}, 0, 0, 1'b0); // one mismatching bit

        // Abort a LOAD after 7 shifts, with a byte handshake in the same cycle.
        cmd_start = 1'b1;
        tick();
        cmd_start     = 1'b0;
        cfg.cfg_data  = 8'h5A;
        cfg.cfg_valid = 1'b1;
        n = 0;
        while (shift_cnt < 7 && n < 100) begin tick(); n++; end
        chk("abort_shift_wait", shift_cnt, 7);
        dc = done_cnt;
        cmd_abort = 1'b1;
        tick();
        cmd_abort     = 1'b0;
        cfg.cfg_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_shift_en", ccff_shift_en, 0);
        sc = shift_cnt;
        repeat (5) tick();
        chk("abort_no_more_shifts", shift_cnt, sc);
        chk("abort_no_done", done_cnt, dc);
        run_op(1'b0, base, 0, 0, 1'b0);                  // restart after abort

        // Reset in the middle of a VERIFY whose first byte fully mismatches.
        s = chain_stream();
        b = ~s[7:0];
        cmd_verify = 1'b1;
        cmd_start  = 1'b1;
        tick();
        cmd_start  = 1'b0;
        cmd_verify = 1'b0;
        send_byte(b, 0);
        cfg.cfg_data = 8'($urandom);
        n = 0;
        while (shift_cnt < 8 && n < 100) begin tick(); n++; end
        chk("mid_verify_fail", verify_fail, 1);
        chk("mid_mismatch_cnt", mismatch_cnt, 8);
        chk("mid_shift_en", ccff_shift_en, 1);
        #2 pReset = 1'b1;
        #1 check_reset("async_reset");
        cfg.cfg_valid = 1'b0;
        @(negedge prog_clk);
        #2 pReset = 1'b0;
        tick();

        run_op(1'b0, {8'($urandom), 8'($urandom), 8'($urandom)}, 0, 0, 1'b1);

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                s = chain_stream();
                for (int i = 0; i < 8 * NB; i++)
                    if ($urandom_range(0, 15) == 0) s[i] = ~s[i];
                if (r % 5 == 4) s = ~s;
                run_op(1'b1, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            end else begin
                s = {8'($urandom), 8'($urandom), 8'($urandom)};
                run_op(1'b0, s, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
